// File: rtl/vec_packer.sv
// Gearbox that packs RATIO narrow slices into one wide word, with an in_last
// flush for partial words and a single-entry output register.
module vec_packer #(
  parameter int IN_W      = 4,
  parameter int RATIO     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_W-1:0]              in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IN_W*RATIO-1:0]        out_data,
  output logic [$clog2(RATIO+1)-1:0]   out_count
);
  localparam int OW = IN_W * RATIO;
  localparam int CW = $clog2(RATIO + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] acc_q, acc_d;
  logic [OW-1:0] out_data_q, out_data_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic          out_valid_q, out_valid_d;
  logic [OW-1:0] acc_ins;
  logic          accept, complete;

  // Accumulator with the incoming slice dropped into the slot selected by cnt.
  for (genvar p = 0; p < RATIO; p++) begin : g_slot
    localparam int K = (MSB_FIRST != 0) ? (RATIO - 1 - p) : p;
    assign acc_ins[p*IN_W +: IN_W] = (cnt_q == CW'(K)) ? in_data : acc_q[p*IN_W +: IN_W];
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign complete = accept && (in_last || (cnt_q == CNT_LAST));

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (complete) begin
      // A completion in the same cycle as a consume reloads without a bubble.
      out_data_d  = acc_ins;
      out_count_d = cnt_q + CW'(1);
      out_valid_d = 1'b1;
      cnt_d       = '0;
      acc_d       = '0;
    end else if (accept) begin
      acc_d = acc_ins;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
endmodule

// File: tb/tb_vec_packer.sv
// Bench for vec_packer: MSB-first and LSB-first instances share stimulus; a
// directed vector table is followed by random traffic against a slice-queue model.
module tb_vec_packer;
  localparam int W  = 4;
  localparam int R  = 2;
  localparam int OW = W * R;
  localparam int CW = $clog2(R + 1);

  logic clk = 1'b0;
  logic rst, in_valid, in_last, out_ready;
  logic [W-1:0] in_data;
  logic in_ready_m, in_ready_l, out_valid_m, out_valid_l;
  logic [OW-1:0] out_data_m, out_data_l;
  logic [CW-1:0] out_count_m, out_count_l;

  always #5 clk = ~clk;

  vec_packer #(.IN_W(W), .RATIO(R), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_m),
    .out_ready(out_ready), .out_data(out_data_m), .out_count(out_count_m));

  vec_packer #(.IN_W(W), .RATIO(R), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_l),
    .out_ready(out_ready), .out_data(out_data_l), .out_count(out_count_l));

  typedef struct {
    logic          rst, v;
    logic [W-1:0]  d;
    logic          l, ordy;
    logic          e_ov;
    logic [OW-1:0] e_m, e_l;
    logic [CW-1:0] e_cnt;
    logic          chk_d;
    logic          e_irdy;
  } vec_t;

  vec_t tbl[$];
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, v, input logic [W-1:0] d, input logic l, ordy,
                     input logic e_ov, input logic [OW-1:0] e_m, e_l,
                     input logic [CW-1:0] e_cnt, input logic chk_d, e_irdy);
    vec_t t;
    t.rst = r; t.v = v; t.d = d; t.l = l; t.ordy = ordy;
    t.e_ov = e_ov; t.e_m = e_m; t.e_l = e_l; t.e_cnt = e_cnt;
    t.chk_d = chk_d; t.e_irdy = e_irdy;
    tbl.push_back(t);
  endtask

  // Reference model state: slices of the word being built and the pending output.
  logic [W-1:0]  slices[$];
  logic          pend;
  logic [OW-1:0] pend_m, pend_l;
  logic [CW-1:0] pend_cnt;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;

    //   rst v  d     l ordy | ov  msb    lsb    cnt chk irdy
    add(1, 0, 4'h0, 0, 1,     0, 8'h00, 8'h00, 0,  1,  1);
    add(0, 1, 4'hA, 0, 1,     0, 8'h00, 8'h00, 0,  0,  1);
    add(0, 1, 4'h5, 0, 1,     1, 8'hA5, 8'h5A, 2,  1,  1);
    add(0, 0, 4'h0, 0, 1,     0, 8'h00, 8'h00, 0,  0,  1);
    add(0, 1, 4'hF, 1, 1,     1, 8'hF0, 8'h0F, 1,  1,  1);
    add(0, 1, 4'h3, 0, 1,     0, 8'h00, 8'h00, 0,  0,  1);
    add(0, 1, 4'hC, 0, 1,     1, 8'h3C, 8'hC3, 2,  1,  1);
    add(0, 1, 4'hA, 0, 1,     0, 8'h00, 8'h00, 0,  0,  1);
    add(0, 1, 4'h5, 0, 0,     1, 8'hA5, 8'h5A, 2,  1,  0);
    for (int i = 0; i < 5; i++)
      add(0, 1, 4'h9, 0, 0,   1, 8'hA5, 8'h5A, 2,  1,  0);
    add(0, 0, 4'h0, 0, 1,     0, 8'h00, 8'h00, 0,  0,  1);
    add(0, 1, 4'h1, 0, 1,     0, 8'h00, 8'h00, 0,  0,  1);
    add(0, 1, 4'h2, 0, 1,     1, 8'h12, 8'h21, 2,  1,  1);
    add(0, 1, 4'h3, 0, 1,     0, 8'h00, 8'h00, 0,  0,  1);
    add(0, 1, 4'h4, 0, 1,     1, 8'h34, 8'h43, 2,  1,  1);
    add(0, 1, 4'hB, 1, 1,     1, 8'hB0, 8'h0B, 1,  1,  1);
    add(0, 1, 4'h6, 0, 1,     0, 8'h00, 8'h00, 0,  0,  1);
    add(0, 1, 4'h7, 1, 1,     1, 8'h67, 8'h76, 2,  1,  1);
    add(0, 1, 4'h7, 0, 1,     0, 8'h00, 8'h00, 0,  0,  1);
    add(1, 1, 4'hE, 0, 1,     0, 8'h00, 8'h00, 0,  1,  1);
    add(0, 1, 4'h1, 0, 1,     0, 8'h00, 8'h00, 0,  0,  1);
    add(0, 1, 4'h2, 0, 1,     1, 8'h12, 8'h21, 2,  1,  1);
    add(0, 0, 4'h0, 0, 1,     0, 8'h00, 8'h00, 0,  0,  1);

    @(negedge clk);
    foreach (tbl[i]) begin
      rst = tbl[i].rst; in_valid = tbl[i].v; in_data = tbl[i].d;
      in_last = tbl[i].l; out_ready = tbl[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("row%0d ov_m", i), 32'(out_valid_m), 32'(tbl[i].e_ov));
      chk($sformatf("row%0d ov_l", i), 32'(out_valid_l), 32'(tbl[i].e_ov));
      chk($sformatf("row%0d irdy_m", i), 32'(in_ready_m), 32'(tbl[i].e_irdy));
      chk($sformatf("row%0d irdy_l", i), 32'(in_ready_l), 32'(tbl[i].e_irdy));
      if (tbl[i].chk_d) begin
        chk($sformatf("row%0d data_m", i), 32'(out_data_m), 32'(tbl[i].e_m));
        chk($sformatf("row%0d data_l", i), 32'(out_data_l), 32'(tbl[i].e_l));
        chk($sformatf("row%0d cnt_m", i), 32'(out_count_m), 32'(tbl[i].e_cnt));
        chk($sformatf("row%0d cnt_l", i), 32'(out_count_l), 32'(tbl[i].e_cnt));
      end
    end

    // Random traffic; begin from a clean reset so the model starts empty.
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    slices.delete(); pend = 1'b0; pend_m = '0; pend_l = '0; pend_cnt = '0;
    for (int c = 0; c < 3000; c++) begin
      logic acc;
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk($sformatf("rnd%0d irdy_m", c), 32'(in_ready_m), 32'(!pend || out_ready));
      chk($sformatf("rnd%0d irdy_l", c), 32'(in_ready_l), 32'(!pend || out_ready));
      chk($sformatf("rnd%0d ov_m", c), 32'(out_valid_m), 32'(pend));
      chk($sformatf("rnd%0d ov_l", c), 32'(out_valid_l), 32'(pend));
      if (pend) begin
        chk($sformatf("rnd%0d data_m", c), 32'(out_data_m), 32'(pend_m));
        chk($sformatf("rnd%0d data_l", c), 32'(out_data_l), 32'(pend_l));
        chk($sformatf("rnd%0d cnt_m", c), 32'(out_count_m), 32'(pend_cnt));
      end
      acc = in_valid && (!pend || out_ready);
      if (rst) begin
        slices.delete(); pend = 1'b0;
      end else begin
        if (pend && out_ready) pend = 1'b0;
        if (acc) begin
          slices.push_back(in_data);
          if (in_last || slices.size() == R) begin
            pend_m = '0; pend_l = '0;
            foreach (slices[k]) begin
              pend_m |= OW'(slices[k]) << ((R - 1 - k) * W);
              pend_l |= OW'(slices[k]) << (k * W);
            end
            pend_cnt = CW'(slices.size());
            pend = 1'b1;
            slices.delete();
          end
        end
      end
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/vec_packer.md
VEC_PACKER -- requirements
Module: vec_packer

Interface
REQ-001 The block SHALL have parameter IN_W, default 4, giving the input slice width in bits (>=1).
REQ-002 The block SHALL have parameter RATIO, default 2, giving the number of slices per output word (>=2).
REQ-003 The block SHALL have parameter MSB_FIRST, default 1: 1 = first slice in the most significant position, 0 = first slice in the least significant position.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data/in_last qualify.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept a slice this cycle.
REQ-008 The block SHALL have port in_data, input, IN_W bits: input slice.
REQ-009 The block SHALL have port in_last, input, 1 bit: the accepted slice closes the current word (flush).
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data/out_count hold a packed word.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer takes the word this cycle.
REQ-012 The block SHALL have port out_data, output, IN_W*RATIO bits: packed word.
REQ-013 The block SHALL have port out_count, output, $clog2(RATIO+1) bits: number of valid slices in out_data (1..RATIO).

Function
REQ-014 The block SHALL accept a slice when in_valid && in_ready; this is an "accept".
REQ-015 The block SHALL drive in_ready = !out_valid || out_ready (combinational).
REQ-016 The block SHALL keep fill counter cnt (0..RATIO-1) and an IN_W*RATIO-bit accumulator; slice k of a word (k = cnt at accept) goes to bits [(RATIO-1-k)*IN_W +: IN_W] when MSB_FIRST=1, or [k*IN_W +: IN_W] when MSB_FIRST=0.
REQ-017 On accept with cnt<RATIO-1 and in_last=0, the block SHALL store the slice and increment cnt.
REQ-018 On accept with cnt==RATIO-1 or in_last=1 ("completion"), the block SHALL on the next edge load out_data with the accumulator including this slice, set out_count=cnt+1, set out_valid=1, clear cnt to 0 and clear the accumulator to zero.
REQ-019 The block SHALL zero all unfilled slice positions of a partial (in_last) word; filled slices keep their positions per REQ-016.
REQ-020 Latency SHALL be one cycle: out_valid rises on the edge that registers the completing accept.
REQ-021 While out_valid=1 and out_ready=0, the block SHALL hold out_data, out_count and out_valid stable and accept nothing.
REQ-022 On out_valid && out_ready with no completion in the same cycle, the block SHALL clear out_valid on the next edge; out_data may retain the old value.
REQ-023 On out_valid && out_ready with a completion in the same cycle, the block SHALL keep out_valid=1 and load the new word (no bubble, no loss).
REQ-024 Non-completing accepts SHALL proceed while out_valid=1 only when out_ready=1 (per REQ-015); no slice SHALL ever be dropped or duplicated.
REQ-025 The block SHALL ignore in_data and in_last when no accept occurs.

Reset
REQ-026 With rst=1 at an edge, the block SHALL set out_valid=0, out_data=0, out_count=0, cnt=0 and accumulator=0; rst SHALL take priority over all other events.
REQ-027 A partially filled word or pending output at reset SHALL be discarded; the first accept after reset is slice 0 of a new word.

Verification (IN_W=4, RATIO=2 unless stated)
REQ-028 MSB_FIRST=1, out_ready=1, accept 4'hA then 4'h5 -> one cycle after the second accept, out_data=8'hA5, out_count=2, out_valid=1 for one cycle.
REQ-029 MSB_FIRST=0, same stimulus -> out_data=8'h5A, out_count=2.
REQ-030 MSB_FIRST=1, accept 4'hF with in_last=1 -> out_data=8'hF0, out_count=1; next accept 4'h3, 4'hC -> out_data=8'h3C.
REQ-031 out_ready=0 after word 8'hA5 completes -> out_valid, out_data held for 5 cycles, in_ready=0; raise out_ready -> word taken once, in_ready=1.
REQ-032 Continuous in_valid=1, out_ready=1, slices 1,2,3,4 -> words 8'h12 then 8'h34, no slice lost, in_ready never 0.
REQ-033 Accept 4'h7 (cnt=1), assert rst one cycle, then accept 4'h1, 4'h2 -> out_valid=0 during/after reset until out_data=8'h12, out_count=2.
